lc3_mem_ctrl: RTL and testbench

//  Memory/IO access sequencer between the LC-3 control FSM and the memory array and devices.

---
 rtl/lc3_mem_ctrl_if.sv | 23 ++
 rtl/lc3_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
// Control-side handshake between the LC-3 control FSM and the memory/IO sequencer.
// The master drives an access request (MIO.EN, R.W, MAR, MDR, PSR[15]).
// The slave answers with the ready pulse, the read data and the access-violation flag.
interface lc3_mem_ctrl_if;
   logic        mio_en;
   logic        r_w;
   logic [15:0] mar;
   logic [15:0] mdr_in;
   logic        psr_user;
   logic [15:0] mdr_out;
   logic        r;
   logic        acv;

   modport master (
      output mio_en, r_w, mar, mdr_in, psr_user,
      input  mdr_out, r, acv
   );

   modport slave (
      input  mio_en, r_w, mar, mdr_in, psr_user,
      output mdr_out, r, acv
   );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO access sequencer.
// It accepts one MAR/MDR access per MIO.EN request and has three outcomes:
//  - a RAM cycle that holds mem_en for exactly MEM_LAT cycles and then pulses R;
//  - a memory-mapped device access (xFE00..xFFFF) that pulses R one cycle after the request;
//  - a user-mode access violation, which pulses R together with ACV and has no side effects.
// The violation check exists only when LC3_MEM_ACV_EN is defined.
// Without that macro, psr_user is ignored and acv stays 0.
// Every output comes straight from a register, so the asynchronous reset clears mem_en at once.
module lc3_mem_ctrl #(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   lc3_mem_ctrl_if.slave     ctl,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [15:0]       mem_wdata_o,
   input  logic [15:0]       mem_rdata_i,
   input  logic              kbd_valid_i,
   input  logic [7:0]        kbd_data_i,
   output logic              kbd_ack_o,
   input  logic              dsp_ready_i,
   output logic [7:0]        ddr_data_o,
   output logic              ddr_we_o,
   output logic              mcr_run_o
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              r_q, r_d;
   logic              acv_q, acv_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       mdr_out_q, mdr_out_d;
   logic              kbd_ack_q, kbd_ack_d;
   logic [7:0]        ddr_data_q, ddr_data_d;
   logic              ddr_we_q, ddr_we_d;
   logic              mcr_run_q, mcr_run_d;
   logic              acv_hit_s;

   // The device page is xFE00..xFFFF, which is where the upper seven address bits are all ones.
   function automatic logic is_dev_addr(input logic [15:0] addr);
      return (addr[15:9] == 7'h7F);
   endfunction

   // Read value of a device register; unmapped device addresses read as zero.
   function automatic logic [15:0] dev_read(input logic [15:0] addr,
                                            input logic        kbd_valid,
                                            input logic [7:0]  kbd_data,
                                            input logic        dsp_ready,
                                            input logic        mcr_run);
      logic [15:0] val;
      case (addr)
         ADDR_KBSR: val = {kbd_valid, 15'h0000};
         ADDR_KBDR: val = {8'h00, kbd_data};
         ADDR_DSR:  val = {dsp_ready, 15'h0000};
         ADDR_DDR:  val = 16'h0000;
         ADDR_MCR:  val = {mcr_run, 15'h0000};
         default:   val = 16'h0000;
      endcase
      return val;
   endfunction

   // Flag user-mode requests that target system space (low memory or the device page).
   always_comb begin
`ifdef LC3_MEM_ACV_EN
      acv_hit_s = ctl.psr_user && ((ctl.mar < 16'h3000) || is_dev_addr(ctl.mar));
`else
      acv_hit_s = 1'b0;
`endif
   end

   // Next-state and next-output logic of the IDLE -> ACCESS -> DONE sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = 1'b0;
      acv_d       = 1'b0;
      kbd_ack_d   = 1'b0;
      ddr_we_d    = 1'b0;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mdr_out_d   = mdr_out_q;
      ddr_data_d  = ddr_data_q;
      mcr_run_d   = mcr_run_q;
      case (state_q)
         ST_IDLE: begin
            if (ctl.mio_en) begin
               if (acv_hit_s) begin
                  state_d   = ST_DONE;
                  r_d       = 1'b1;
                  acv_d     = 1'b1;
                  mdr_out_d = 16'h0000;
               end else if (is_dev_addr(ctl.mar)) begin
                  state_d = ST_DONE;
                  r_d     = 1'b1;
                  if (ctl.r_w) begin
                     case (ctl.mar)
                        ADDR_DDR: begin
                           ddr_data_d = ctl.mdr_in[7:0];
                           ddr_we_d   = 1'b1;
                        end
                        ADDR_MCR: mcr_run_d = ctl.mdr_in[15];
                        default:  mcr_run_d = mcr_run_q;
                     endcase
                  end else begin
                     mdr_out_d = dev_read(ctl.mar, kbd_valid_i, kbd_data_i,
                                          dsp_ready_i, mcr_run_q);
                     kbd_ack_d = (ctl.mar == ADDR_KBDR);
                  end
               end else begin
                  state_d     = ST_ACCESS;
                  cnt_d       = '0;
                  mem_en_d    = 1'b1;
                  mem_we_d    = ctl.r_w;
                  mem_addr_d  = ADDR_W'(ctl.mar);
                  mem_wdata_d = ctl.mdr_in;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d   = ST_DONE;
               mem_en_d  = 1'b0;
               mem_we_d  = 1'b0;
               r_d       = 1'b1;
               mdr_out_d = mem_rdata_i;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         r_q         <= 1'b0;
         acv_q       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 16'h0000;
         mdr_out_q   <= 16'h0000;
         kbd_ack_q   <= 1'b0;
         ddr_data_q  <= 8'h00;
         ddr_we_q    <= 1'b0;
         mcr_run_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         acv_q       <= acv_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mdr_out_q   <= mdr_out_d;
         kbd_ack_q   <= kbd_ack_d;
         ddr_data_q  <= ddr_data_d;
         ddr_we_q    <= ddr_we_d;
         mcr_run_q   <= mcr_run_d;
      end
   end

   assign ctl.r       = r_q;
   assign ctl.acv     = acv_q;
   assign ctl.mdr_out = mdr_out_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign kbd_ack_o   = kbd_ack_q;
   assign ddr_data_o  = ddr_data_q;
   assign ddr_we_o    = ddr_we_q;
   assign mcr_run_o   = mcr_run_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl.
// The bench keeps a behavioural model of the access rules:
//  - a word array for RAM contents;
//  - the device register table;
//  - fixed latencies of 1 cycle (device or violation) and MEM_LAT+1 cycles (RAM).
// Each access is compared against that model.
module tb_lc3_mem_ctrl;
   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        kbd_valid, kbd_ack, dsp_ready, ddr_we, mcr_run;
   logic [7:0]  kbd_data, ddr_data;

   logic [15:0] ram [0:65535];
   bit          written [0:65535];
   logic [15:0] ref_mem [0:65535];
   bit          mcr_exp;
   logic [7:0]  ddr_exp;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   lc3_mem_ctrl_if bus();

   lc3_mem_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .ctl(bus),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .kbd_valid_i(kbd_valid), .kbd_data_i(kbd_data), .kbd_ack_o(kbd_ack),
      .dsp_ready_i(dsp_ready), .ddr_data_o(ddr_data), .ddr_we_o(ddr_we),
      .mcr_run_o(mcr_run)
   );

   // Power-up RAM pattern; x3000 holds x1234 for the basic read scenario.
   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a == 16'h3000) return 16'h1234;
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // RAM attached to the DUT: combinational read, write on the clock edge.
   assign mem_rdata = written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
   end

   function automatic bit acv_exp_f(input logic [15:0] a, input bit user);
`ifdef LC3_MEM_ACV_EN
      return user && ((a < 16'h3000) || (a >= 16'hFE00));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] dev_exp(input logic [15:0] a);
      case (a)
         16'hFE00: return {kbd_valid, 15'h0000};
         16'hFE02: return {8'h00, kbd_data};
         16'hFE04: return {dsp_ready, 15'h0000};
         16'hFFFE: return {mcr_exp, 15'h0000};
         default:  return 16'h0000;
      endcase
   endfunction

   // One full access, started just after a falling edge and finished in the following idle cycle.
   task automatic access(input bit we, input logic [15:0] a, input logic [15:0] wd,
                         input bit user, input bit drop, input string tag);
      bit          is_dev, acv_e, ram_path, seen, exp_ack, exp_ddrwe;
      int          exp_lat, lat, en_n, we_n, bad_bus, ack_n, ack_at, dwe_n, dwe_at;
      logic [15:0] exp_rd, rd_obs, rd_after;
      logic        acv_obs, r_after;
      is_dev    = (a >= 16'hFE00);
      acv_e     = acv_exp_f(a, user);
      ram_path  = !is_dev && !acv_e;
      exp_lat   = ram_path ? MEM_LAT + 1 : 1;
      exp_rd    = acv_e ? 16'h0000 : (is_dev ? dev_exp(a) : ref_mem[a]);
      exp_ack   = !acv_e && !we && (a == 16'hFE02);
      exp_ddrwe = !acv_e && we && (a == 16'hFE06);
      lat = 0; en_n = 0; we_n = 0; bad_bus = 0; ack_n = 0; ack_at = 0; dwe_n = 0; dwe_at = 0;
      seen = 1'b0; rd_obs = 16'h0000; acv_obs = 1'b0;
      bus.mio_en = 1'b1; bus.r_w = we; bus.mar = a; bus.mdr_in = wd; bus.psr_user = user;
      @(posedge clk);
      #1;
      bus.mar = 16'($urandom); bus.mdr_in = 16'($urandom); bus.r_w = ~we;
      bus.psr_user = 1'($urandom_range(0, 1));
      if (drop) bus.mio_en = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_en === 1'b1) begin
            en_n++;
            if (mem_addr !== a) bad_bus++;
            if (mem_we === 1'b1) begin
               we_n++;
               if (mem_wdata !== wd) bad_bus++;
            end
         end
         if (kbd_ack === 1'b1) begin ack_n++; ack_at = lat; end
         if (ddr_we === 1'b1) begin dwe_n++; dwe_at = lat; end
         if (bus.r === 1'b1) begin
            seen = 1'b1; rd_obs = bus.mdr_out; acv_obs = bus.acv;
         end
      end
      if (!acv_e) begin
         if (we && ram_path) ref_mem[a] = wd;
         if (we && a == 16'hFE06) ddr_exp = wd[7:0];
         if (we && a == 16'hFFFE) mcr_exp = wd[15];
      end
      bus.mio_en = 1'b0;
      @(negedge clk);
      r_after = bus.r; rd_after = bus.mdr_out;

      checks++;
      if (!seen) begin
         errors++; $display("FAIL %s timeout: no r within 20 cycles of a=%h", tag, a);
      end else if (lat != exp_lat) begin
         errors++; $display("FAIL %s latency a=%h: got %0d required %0d", tag, a, lat, exp_lat);
      end
      checks++;
      if (en_n != (ram_path ? MEM_LAT : 0) || we_n != ((ram_path && we) ? MEM_LAT : 0)) begin
         errors++;
         $display("FAIL %s mem_en/mem_we cycles a=%h: got %0d/%0d required %0d/%0d", tag, a, en_n, we_n,
                  ram_path ? MEM_LAT : 0, (ram_path && we) ? MEM_LAT : 0);
      end
      checks++;
      if (bad_bus != 0) begin
         errors++; $display("FAIL %s ram bus a=%h: %0d cycles with wrong mem_addr/mem_wdata", tag, a, bad_bus);
      end
      if (!we || acv_e) begin
         checks++;
         if (rd_obs !== exp_rd) begin
            errors++; $display("FAIL %s mdr_out a=%h: got %h required %h", tag, a, rd_obs, exp_rd);
         end
         checks++;
         if (rd_after !== rd_obs) begin
            errors++; $display("FAIL %s mdr_out hold a=%h: got %h required %h", tag, a, rd_after, rd_obs);
         end
      end
      checks++;
      if (acv_obs !== acv_e) begin
         errors++; $display("FAIL %s acv a=%h: got %b required %b", tag, a, acv_obs, acv_e);
      end
      checks++;
      if (ack_n != (exp_ack ? 1 : 0) || (exp_ack && ack_at != lat)) begin
         errors++; $display("FAIL %s kbd_ack a=%h: got %0d pulses at %0d required %0d", tag, a, ack_n, ack_at, exp_ack);
      end
      checks++;
      if (dwe_n != (exp_ddrwe ? 1 : 0) || (exp_ddrwe && dwe_at != lat)) begin
         errors++; $display("FAIL %s ddr_we a=%h: got %0d pulses at %0d required %0d", tag, a, dwe_n, dwe_at, exp_ddrwe);
      end
      checks++;
      if (ddr_data !== ddr_exp || mcr_run !== mcr_exp || r_after !== 1'b0) begin
         errors++;
         $display("FAIL %s device state a=%h: ddr_data=%h mcr_run=%b r_after=%b required %h %b 0",
                  tag, a, ddr_data, mcr_run, r_after, ddr_exp, mcr_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if ({bus.r, bus.acv, mem_en, mem_we, kbd_ack, ddr_we, mcr_run} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_flags: got r,acv,en,we,ack,dwe,run=%b required 0000001",
                  {bus.r, bus.acv, mem_en, mem_we, kbd_ack, ddr_we, mcr_run});
      end
      checks++;
      if ({bus.mdr_out, mem_addr, mem_wdata, ddr_data} !== 56'h0) begin
         errors++;
         $display("FAIL reset_data: got mdr=%h addr=%h wdata=%h ddr=%h required all zero",
                  bus.mdr_out, mem_addr, mem_wdata, ddr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram_read();
      access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, "ram_read");
   endtask

   task automatic test_back_to_back();
      access(1'b1, 16'h3001, 16'hABCD, 1'b0, 1'b0, "b2b_write");
      access(1'b0, 16'h3001, 16'h0000, 1'b0, 1'b0, "b2b_read");
   endtask

   task automatic test_kbd();
      kbd_valid = 1'b1; kbd_data = 8'h41; dsp_ready = 1'b0;
      access(1'b0, 16'hFE00, 16'h0000, 1'b0, 1'b0, "kbsr_read");
      access(1'b0, 16'hFE02, 16'h0000, 1'b0, 1'b0, "kbdr_read");
      access(1'b0, 16'hFE04, 16'h0000, 1'b0, 1'b0, "dsr_read0");
      dsp_ready = 1'b1;
      access(1'b0, 16'hFE04, 16'h0000, 1'b0, 1'b0, "dsr_read1");
      access(1'b0, 16'hFE10, 16'h0000, 1'b0, 1'b0, "unmapped_read");
   endtask

   task automatic test_dev_writes();
      access(1'b1, 16'hFE06, 16'h0048, 1'b0, 1'b0, "ddr_write");
      access(1'b1, 16'hFE00, 16'hFFFF, 1'b0, 1'b0, "kbsr_write");
      access(1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b0, "mcr_write");
      access(1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, "mcr_read");
   endtask

   task automatic test_mio_drop();
      access(1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1, "mio_drop");
   endtask

   task automatic test_reset_mid();
      bit bad;
      bus.mio_en = 1'b1; bus.r_w = 1'b0; bus.mar = 16'h3000; bus.psr_user = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_en !== 1'b0 || bus.r !== 1'b0) begin
         errors++; $display("FAIL reset_mid_abort: mem_en=%b r=%b required 0 0", mem_en, bus.r);
      end
      bus.mio_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mcr_exp = 1'b1; ddr_exp = 8'h00;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.r !== 1'b0 || mem_en !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || mcr_run !== 1'b1) begin
         errors++; $display("FAIL reset_mid_after: stray r/mem_en=%b mcr_run=%b required 0 1", bad, mcr_run);
      end
      access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, "after_reset_read");
   endtask

   task automatic test_acv();
      access(1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, "user_low_read");
      access(1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, "user_ram_read");
      access(1'b1, 16'hFE06, 16'h0055, 1'b1, 1'b0, "user_ddr_write");
      access(1'b1, 16'h2FFF, 16'h7777, 1'b1, 1'b0, "user_low_write");
      access(1'b0, 16'h2FFF, 16'h0000, 1'b0, 1'b0, "super_low_read");
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] devs [7];
      int          k;
      devs = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE08, 16'hFF00, 16'hFFFE};
      for (int n = 0; n < 60; n++) begin
         k = int'($urandom_range(0, 9));
         if (k <= 2)      a = 16'h3000 + 16'($urandom_range(0, 15));
         else if (k == 3) a = 16'($urandom_range(0, 16'h2FFF));
         else if (k <= 5) a = 16'($urandom_range(0, 16'hFDFF));
         else if (k <= 8) a = devs[$urandom_range(0, 6)];
         else             a = 16'($urandom_range(16'hFE00, 16'hFFFF));
         kbd_valid = 1'($urandom_range(0, 1));
         kbd_data  = 8'($urandom);
         dsp_ready = 1'($urandom_range(0, 1));
         access(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.mio_en = 1'b0; bus.r_w = 1'b0; bus.mar = 16'h0000; bus.mdr_in = 16'h0000; bus.psr_user = 1'b0;
      kbd_valid = 1'b0; kbd_data = 8'h00; dsp_ready = 1'b0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
      mcr_exp = 1'b1;
      ddr_exp = 8'h00;
      test_reset();
      test_ram_read();
      test_back_to_back();
      test_kbd();
      test_dev_writes();
      test_mio_drop();
      test_reset_mid();
      test_acv();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
